// File: rtl/kl_code_pkg.sv
// KL digit code constants and receiver state encoding, shared by the KL encoder and decoder.
package kl_code_pkg;

    localparam logic [6:0] KL_CODE_0    = 7'b1111110;
    localparam logic [6:0] KL_CODE_1    = 7'b1000000;
    localparam logic [6:0] KL_CODE_2    = 7'b1000001;
    localparam logic [6:0] KL_CODE_3    = 7'b1001001;
    localparam logic [6:0] KL_CODE_4    = 7'b0100011;
    localparam logic [6:0] KL_CODE_5    = 7'b0011101;
    localparam logic [6:0] KL_CODE_6    = 7'b0100101;
    localparam logic [6:0] KL_CODE_7    = 7'b0010011;
    localparam logic [6:0] KL_CODE_8    = 7'b0110110;
    localparam logic [6:0] KL_CODE_9    = 7'b0110111;
    localparam logic [6:0] KL_CODE_TERM = 7'b0000000;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_OUT     = 2'd2
    } kl_state_t;

endpackage

// File: rtl/kl_code_lookup.sv
// KL codeword classifier: 7-bit code -> {is_digit, is_term, digit}.
// Latency: purely combinational.
// Backpressure: none, no state.
module kl_code_lookup
    import kl_code_pkg::*;
(
    input  logic [6:0] i_code,
    output logic       o_is_digit,
    output logic       o_is_term,
    output logic [3:0] o_digit
);

    always_comb begin
        o_is_digit = 1'b1;
        o_is_term  = 1'b0;
        o_digit    = 4'd0;
        case (i_code)
            KL_CODE_0:    o_digit = 4'd0;
            KL_CODE_1:    o_digit = 4'd1;
            KL_CODE_2:    o_digit = 4'd2;
            KL_CODE_3:    o_digit = 4'd3;
            KL_CODE_4:    o_digit = 4'd4;
            KL_CODE_5:    o_digit = 4'd5;
            KL_CODE_6:    o_digit = 4'd6;
            KL_CODE_7:    o_digit = 4'd7;
            KL_CODE_8:    o_digit = 4'd8;
            KL_CODE_9:    o_digit = 4'd9;
            KL_CODE_TERM: begin
                o_is_digit = 1'b0;
                o_is_term  = 1'b1;
            end
            default:      o_is_digit = 1'b0;
        endcase
    end

endmodule

// File: rtl/kl_code_decoder_rx.sv
// KL code receiver: assembles up to DIGITS decoded digits into one BCD word (optional KL_ERRCNT_EN error counter).
// Latency: word valid one cycle after the accept of its last digit or TERM.
// Backpressure: in_ready low while a completed word waits for out_ready.
module kl_code_decoder_rx
    import kl_code_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [6:0]            in_code,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [4*DIGITS-1:0]   out_bcd,
    output logic [3:0]            out_count,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_err
`ifdef KL_ERRCNT_EN
    ,
    output logic [7:0]            err_count
`endif
);

    localparam int W = 4 * DIGITS;

    kl_state_t      r_state;
    logic [W-1:0]   r_acc;
    logic [3:0]     r_cnt;
    logic [W-1:0]   r_out_bcd;
    logic [3:0]     r_out_count;
    logic           r_out_valid;
    logic           r_out_err;

    logic           w_is_digit;
    logic           w_is_term;
    logic [3:0]     w_digit;
    logic           w_accept;
    logic           w_invalid;
    logic [W-1:0]   w_acc_shift;
    logic [3:0]     w_cnt_inc;

    kl_code_lookup u_lookup (
        .i_code     (in_code),
        .o_is_digit (w_is_digit),
        .o_is_term  (w_is_term),
        .o_digit    (w_digit)
    );

    assign in_ready    = (r_state != ST_OUT);
    assign w_accept    = in_valid & in_ready;
    assign w_invalid   = w_accept & ~w_is_digit & ~w_is_term;
    // Shift left by one digit; for DIGITS==1 the shift empties the word, leaving only the new digit.
    assign w_acc_shift = (r_acc << 4) | W'(w_digit);
    assign w_cnt_inc   = r_cnt + 4'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_acc       <= '0;
            r_cnt       <= 4'd0;
            r_out_bcd   <= '0;
            r_out_count <= 4'd0;
            r_out_valid <= 1'b0;
            r_out_err   <= 1'b0;
        end else begin
            r_out_err <= 1'b0;
            case (r_state)
                ST_IDLE, ST_COLLECT: begin
                    if (w_accept) begin
                        if (w_is_digit) begin
                            r_acc <= w_acc_shift;
                            r_cnt <= w_cnt_inc;
                            if (w_cnt_inc == 4'(DIGITS)) begin
                                r_state     <= ST_OUT;
                                r_out_bcd   <= w_acc_shift;
                                r_out_count <= w_cnt_inc;
                                r_out_valid <= 1'b1;
                            end else begin
                                r_state <= ST_COLLECT;
                            end
                        end else if (w_is_term) begin
                            // TERM on an empty word is a no-op.
                            if (r_cnt != 4'd0) begin
                                r_state     <= ST_OUT;
                                r_out_bcd   <= r_acc;
                                r_out_count <= r_cnt;
                                r_out_valid <= 1'b1;
                            end
                        end else begin
                            r_out_err <= 1'b1;
                            r_acc     <= '0;
                            r_cnt     <= 4'd0;
                            r_state   <= ST_IDLE;
                        end
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_acc       <= '0;
                        r_cnt       <= 4'd0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign out_bcd   = r_out_bcd;
    assign out_count = r_out_count;
    assign out_valid = r_out_valid;
    assign out_err   = r_out_err;

`ifdef KL_ERRCNT_EN
    logic [7:0] r_err_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err_count <= 8'd0;
        end else if (w_invalid && (r_err_count != 8'hFF)) begin
            r_err_count <= r_err_count + 8'd1;
        end
    end

    assign err_count = r_err_count;
`endif

endmodule

// File: tb/tb_kl_code_decoder_rx.sv
// Directed bench for kl_code_decoder_rx: word table plus hand-written multi-cycle sequences.
module tb_kl_code_decoder_rx;

    localparam logic [6:0] C0 = 7'b1111110;
    localparam logic [6:0] C1 = 7'b1000000;
    localparam logic [6:0] C2 = 7'b1000001;
    localparam logic [6:0] C3 = 7'b1001001;
    localparam logic [6:0] C4 = 7'b0100011;
    localparam logic [6:0] C5 = 7'b0011101;
    localparam logic [6:0] C6 = 7'b0100101;
    localparam logic [6:0] C7 = 7'b0010011;
    localparam logic [6:0] C8 = 7'b0110110;
    localparam logic [6:0] C9 = 7'b0110111;
    localparam logic [6:0] CT = 7'b0000000;
    localparam logic [6:0] CX = 7'b1010101;
    localparam logic [6:0] CF = 7'b1111111;

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  in_code;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] out_bcd;
    logic [3:0]  out_count;
    logic        out_valid;
    logic        out_ready;
    logic        out_err;

    logic [6:0]  in_code1;
    logic        in_valid1;
    logic        in_ready1;
    logic [3:0]  out_bcd1;
    logic [3:0]  out_count1;
    logic        out_valid1;
    logic        out_ready1;
    logic        out_err1;
`ifdef KL_ERRCNT_EN
    logic [7:0]  err_count;
    logic [7:0]  err_count1;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    kl_code_decoder_rx #(.DIGITS(4)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .in_code   (in_code),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_bcd   (out_bcd),
        .out_count (out_count),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_err   (out_err)
`ifdef KL_ERRCNT_EN
        ,
        .err_count (err_count)
`endif
    );

    kl_code_decoder_rx #(.DIGITS(1)) u_dut1 (
        .clk       (clk),
        .reset     (reset),
        .in_code   (in_code1),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .out_bcd   (out_bcd1),
        .out_count (out_count1),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .out_err   (out_err1)
`ifdef KL_ERRCNT_EN
        ,
        .err_count (err_count1)
`endif
    );

    typedef struct {
        logic [6:0]  c [4];
        int          n;
        logic        err;
        logic [15:0] bcd;
        logic [3:0]  cnt;
    } word_t;

    word_t tbl [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Present a code and hold it until accepted; returns #1 after the accepting edge.
    task automatic send(input logic [6:0] c);
        int bound;
        bound    = 0;
        in_code  = c;
        in_valid = 1'b1;
        while (!in_ready && bound < 50) begin
            @(posedge clk); #1;
            bound++;
        end
        if (bound >= 50) chk("send_timeout", 32'd1, 32'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic take();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("take_out_valid", out_valid, 1'b0);
        chk("take_in_ready", in_ready, 1'b1);
    endtask

    task automatic chk_word(input string name, input logic [15:0] bcd, input logic [3:0] cnt);
        chk({name, "_valid"}, out_valid, 1'b1);
        chk({name, "_bcd"}, out_bcd, bcd);
        chk({name, "_count"}, out_count, cnt);
        chk({name, "_in_ready"}, in_ready, 1'b0);
    endtask

    initial begin
        int errs;

        tbl[0] = '{c: '{C3, C4, C8, C0}, n: 4, err: 1'b0, bcd: 16'h3480, cnt: 4'd4};
        tbl[1] = '{c: '{C2, C7, CT, CT}, n: 3, err: 1'b0, bcd: 16'h0027, cnt: 4'd2};
        tbl[2] = '{c: '{C1, CX, CT, CT}, n: 2, err: 1'b1, bcd: 16'h0000, cnt: 4'd0};
        tbl[3] = '{c: '{C9, CT, CT, CT}, n: 2, err: 1'b0, bcd: 16'h0009, cnt: 4'd1};
        tbl[4] = '{c: '{C5, C6, C1, C2}, n: 4, err: 1'b0, bcd: 16'h5612, cnt: 4'd4};
        tbl[5] = '{c: '{CT, C0, C9, CT}, n: 4, err: 1'b0, bcd: 16'h0009, cnt: 4'd2};
        tbl[6] = '{c: '{CF, CT, CT, CT}, n: 1, err: 1'b1, bcd: 16'h0000, cnt: 4'd0};
        tbl[7] = '{c: '{C1, C2, C3, CT}, n: 4, err: 1'b0, bcd: 16'h0123, cnt: 4'd3};

        reset      = 1'b1;
        in_code    = 7'd0;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        in_code1   = 7'd0;
        in_valid1  = 1'b0;
        out_ready1 = 1'b0;
        #12;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_bcd", out_bcd, 16'h0);
        chk("rst_out_count", out_count, 4'd0);
        chk("rst_out_err", out_err, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
`ifdef KL_ERRCNT_EN
        chk("rst_err_count", err_count, 8'd0);
`endif
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < tbl[i].n; j++) send(tbl[i].c[j]);
            if (tbl[i].err) begin
                chk($sformatf("tbl%0d_err", i), out_err, 1'b1);
                chk($sformatf("tbl%0d_novalid", i), out_valid, 1'b0);
                @(posedge clk); #1;
                chk($sformatf("tbl%0d_err_drop", i), out_err, 1'b0);
            end else begin
                chk_word($sformatf("tbl%0d", i), tbl[i].bcd, tbl[i].cnt);
                take();
            end
        end

`ifdef KL_ERRCNT_EN
        chk("err_count_two", err_count, 8'd2);
`endif

        // Completed word stalls a pending code until the consumer takes it.
        send(C3); send(C4); send(C8); send(C0);
        in_code  = C5;
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk("stall_bcd", out_bcd, 16'h3480);
            chk("stall_in_ready", in_ready, 1'b0);
            chk("stall_valid", out_valid, 1'b1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("stall_release_ready", in_ready, 1'b1);
        chk("stall_release_valid", out_valid, 1'b0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        send(CT);
        chk_word("pending", 16'h0005, 4'd1);
        take();

        // Reset mid-word discards it.
        send(C1); send(C2);
        reset = 1'b1;
        #2;
        chk("midrst_valid", out_valid, 1'b0);
        chk("midrst_bcd", out_bcd, 16'h0);
        chk("midrst_count", out_count, 4'd0);
        chk("midrst_err", out_err, 1'b0);
        #3;
        reset = 1'b0;
        @(posedge clk); #1;
        chk("postrst_valid", out_valid, 1'b0);
        send(C9); send(C8); send(C7); send(C6);
        chk_word("postrst", 16'h9876, 4'd4);
        take();

        // Back-to-back invalid codes: one error pulse per accept.
        errs     = 0;
        in_code  = CX;
        in_valid = 1'b1;
        repeat (300) begin
            @(posedge clk); #1;
            if (out_err) errs++;
        end
        in_valid = 1'b0;
        chk("err_pulses", errs, 300);
        chk("err_stream_novalid", out_valid, 1'b0);
        @(posedge clk); #1;
        chk("err_stream_end", out_err, 1'b0);
`ifdef KL_ERRCNT_EN
        chk("err_count_sat", err_count, 8'd255);
`endif

        // Single-digit configuration.
        in_code1  = CT;
        in_valid1 = 1'b1;
        @(posedge clk); #1;
        in_valid1 = 1'b0;
        chk("d1_term_novalid", out_valid1, 1'b0);
        chk("d1_term_noerr", out_err1, 1'b0);
        in_code1  = C8;
        in_valid1 = 1'b1;
        @(posedge clk); #1;
        in_valid1 = 1'b0;
        chk("d1_valid", out_valid1, 1'b1);
        chk("d1_bcd", out_bcd1, 4'h8);
        chk("d1_count", out_count1, 4'd1);
        chk("d1_in_ready", in_ready1, 1'b0);
        out_ready1 = 1'b1;
        @(posedge clk); #1;
        out_ready1 = 1'b0;
        chk("d1_take", out_valid1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
